// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Default register-index width (32 architectural registers).
    localparam int REG_W       = 5;
    // Width of the saturating stall counter.
    localparam int STALL_CNT_W = 16;
    // Width of the mult/div down-counter.
    localparam int CNT_W       = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: step when enabled unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and
// mult/div hold, driving wen/flush of the IF/ID, ID/EX, EX/MEM regs and PC.
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 8,
    parameter int REG_W         = pipe_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_j_jump,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             muldiv_done,
    output logic [15:0]      stall_count
);

    import pipe_ctrl_pkg::*;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    // Load in EX feeds a source of the ID instruction; r0 is hardwired zero.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State and mult/div counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter MULDIV on an unbranched mult/div, leave when cnt hits 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // The start cycle is one of the MULDIV_CYCLES, and the
                // cnt==0 cycle is the last, hence the -2.
                if (!ex_branch_taken && ex_muldiv) begin
                    state_d = MULDIV;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 2);
                end
            end
            MULDIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Control outputs: priority branch > muldiv > load-use > jump > run.
    always_comb begin
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        muldiv_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_muldiv) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_wen    = 1'b0;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_j_jump) begin
                    ifid_flush = 1'b1;
                end
            end
            MULDIV: begin
                if (cnt_q != '0) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_wen    = 1'b0;
                    exmem_flush = 1'b1;
                end else begin
                    // Result leaves EX; ID-side hazards still need handling.
                    muldiv_done = 1'b1;
                    if (load_use) begin
                        pc_wen     = 1'b0;
                        ifid_wen   = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_j_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
        endcase
        // Hold every pipe register quiet while reset is asserted.
        if (!reset_n) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_wen    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            muldiv_done = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~pc_wen),
        .count   (stall_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    localparam int MDC = 8;

    // Output packing: {pc_wen, ifid_wen, idex_wen, ifid_flush, idex_flush, exmem_flush, muldiv_done}
    localparam logic [6:0] E_RST     = 7'b000_000_0;
    localparam logic [6:0] E_RUN     = 7'b111_000_0;
    localparam logic [6:0] E_LU      = 7'b001_010_0;
    localparam logic [6:0] E_MD      = 7'b000_001_0;
    localparam logic [6:0] E_DONE    = 7'b111_000_1;
    localparam logic [6:0] E_DONE_LU = 7'b001_010_1;
    localparam logic [6:0] E_DONE_J  = 7'b111_100_1;
    localparam logic [6:0] E_J       = 7'b111_100_0;
    localparam logic [6:0] E_BR      = 7'b111_110_0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_j_jump, ex_mem_read, ex_branch_taken, ex_muldiv;
    logic        pc_wen, ifid_wen, idex_wen, ifid_flush, idex_flush, exmem_flush, muldiv_done;
    logic [15:0] stall_count;
    logic [6:0]  outs;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          sc_exp = 0;
    logic [6:0]  sb[$];

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       j;
        logic       br;
        logic       md;
        logic [6:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MULDIV_CYCLES (MDC),
        .REG_W         (5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_j_jump       (id_j_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv       (ex_muldiv),
        .pc_wen          (pc_wen),
        .ifid_wen        (ifid_wen),
        .idex_wen        (idex_wen),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .muldiv_done     (muldiv_done),
        .stall_count     (stall_count)
    );

    assign outs = {pc_wen, ifid_wen, idex_wen, ifid_flush, idex_flush, exmem_flush, muldiv_done};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit mr, input int ert, input int rs,
                                input int rt, input bit uses, input bit j, input bit br,
                                input bit md, input logic [6:0] e);
        vec_t v;
        v.name = nm; v.mr = mr; v.ert = 5'(ert); v.rs = 5'(rs); v.rt = 5'(rt);
        v.uses = uses; v.j = j; v.br = br; v.md = md; v.exp = e;
        return v;
    endfunction

    // One cycle: check accumulated stall count, drive, check outputs via the scoreboard.
    task automatic apply(input vec_t v);
        logic [6:0] e;
        @(negedge clk);
        chk({v.name, "_stall_count"}, 32'(stall_count), 32'(sc_exp));
        ex_mem_read     = v.mr;
        ex_rt           = v.ert;
        id_rs           = v.rs;
        id_rt           = v.rt;
        id_uses_rt      = v.uses;
        id_j_jump       = v.j;
        ex_branch_taken = v.br;
        ex_muldiv       = v.md;
        sb.push_back(v.exp);
        #1;
        e = sb.pop_front();
        chk(v.name, 32'(outs), 32'(e));
        if (!e[6]) sc_exp = (sc_exp == 65535) ? 65535 : sc_exp + 1;
    endtask

    vec_t tbl[14];
    vec_t idle;

    initial begin
        idle    = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[0]  = mk("run",          0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[1]  = mk("lu_rs",        1, 5, 5, 0, 0, 0, 0, 0, E_LU);
        tbl[2]  = mk("after_lu",     0, 5, 5, 0, 0, 0, 0, 0, E_RUN);
        tbl[3]  = mk("lu_r0",        1, 0, 0, 0, 1, 0, 0, 0, E_RUN);
        tbl[4]  = mk("lu_rt",        1, 7, 3, 7, 1, 0, 0, 0, E_LU);
        tbl[5]  = mk("rt_unused",    1, 7, 3, 7, 0, 0, 0, 0, E_RUN);
        tbl[6]  = mk("lu_b2b_a",     1, 9, 9, 0, 0, 0, 0, 0, E_LU);
        tbl[7]  = mk("lu_b2b_b",     1, 12, 12, 12, 1, 0, 0, 0, E_LU);
        tbl[8]  = mk("no_load",      0, 9, 9, 9, 1, 0, 0, 0, E_RUN);
        tbl[9]  = mk("jump",         0, 0, 0, 0, 0, 1, 0, 0, E_J);
        tbl[10] = mk("lu_over_jump", 1, 4, 4, 0, 0, 1, 0, 0, E_LU);
        tbl[11] = mk("br_lu_md",     1, 5, 5, 5, 1, 1, 1, 1, E_BR);
        tbl[12] = mk("after_br",     0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[13] = mk("branch",       0, 0, 0, 0, 0, 0, 1, 0, E_BR);

        // Reset state, checked before any clock edge.
        reset_n = 1'b0;
        ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        id_uses_rt = 0; id_j_jump = 0; ex_branch_taken = 0; ex_muldiv = 0;
        #2;
        chk("reset_outs", 32'(outs), 32'(E_RST));
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // Mult/div held: MDC-1 stalls then a done cycle.
        begin
            int sc_before;
            sc_before = sc_exp;
            for (int c = 1; c <= MDC; c++)
                apply(mk($sformatf("md_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 1, (c < MDC) ? E_MD : E_DONE));
            @(posedge clk); #1;
            chk("md_stall_delta", 32'(stall_count) - 32'(sc_before), 32'(MDC - 1));
        end
        apply(mk("md_after", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Mult/div: branch ignored mid-op, load-use honoured on the done cycle.
        apply(mk("md2_c1", 0, 0, 0, 0, 0, 0, 0, 1, E_MD));
        apply(mk("md2_br", 0, 0, 0, 0, 0, 0, 1, 1, E_MD));
        for (int c = 3; c < MDC; c++)
            apply(mk($sformatf("md2_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, E_MD));
        apply(mk("md2_done_lu", 1, 6, 6, 0, 0, 0, 0, 0, E_DONE_LU));
        apply(mk("md2_after", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Mult/div: jump honoured on the done cycle.
        for (int c = 1; c < MDC; c++)
            apply(mk($sformatf("md3_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 1, E_MD));
        apply(mk("md3_done_j", 0, 0, 0, 0, 0, 1, 0, 1, E_DONE_J));
        apply(mk("md3_after", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Async reset while in MULDIV at cnt==3 (fifth cycle of the op).
        for (int c = 1; c <= 5; c++)
            apply(mk($sformatf("md4_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 1, E_MD));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs), 32'(E_RST));
        chk("async_rst_stall_count", 32'(stall_count), 32'd0);
        sc_exp = 0;
        ex_muldiv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) apply(mk($sformatf("post_rst%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Saturation: hold a load-use hazard for 65540 cycles.
        @(negedge clk);
        ex_mem_read = 1; ex_rt = 5'd3; id_rs = 5'd3;
        #1;
        chk("sat_stall_outs", 32'(outs), 32'(E_LU));
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_hold", 32'(stall_count), 32'h0000_FFFF);
        sc_exp = 65535;
        apply(idle);
        apply(mk("sat_more", 1, 3, 3, 0, 0, 0, 0, 0, E_LU));
        apply(idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
